// File: rtl/ysyx_23060025_ifu_fetch.sv
// Instruction fetch front end: one AR/R read per PC, result handed to the IDU over valid/ready.
// The FSM state is exported so the PC counter only advances on a completed WAIT_FINISH exit.
module ysyx_23060025_ifu_fetch #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32,
  parameter logic [ADDR_LEN-1:0] PC_RESET_VAL = 32'h8000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic                last_finish_i,
  output logic [1:0]          con_state_o,
  output logic                arvalid_o,
  output logic [ADDR_LEN-1:0] araddr_o,
  input  logic                arready_i,
  input  logic                rvalid_i,
  input  logic [DATA_LEN-1:0] rdata_i,
  input  logic [1:0]          rresp_i,
  output logic                rready_o,
  output logic [DATA_LEN-1:0] inst_o,
  output logic [ADDR_LEN-1:0] inst_pc_o,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic                inst_fault_o
);

  // The reset PC is only meaningful if the first fetch can be issued from it.
  if (PC_RESET_VAL[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("PC_RESET_VAL must be word aligned");
  end

  typedef enum logic [1:0] {
    StIdle       = 2'b00,
    StReq        = 2'b01,
    StWaitFinish = 2'b10,
    StResp       = 2'b11
  } state_e;

  state_e              state_q, state_d;
  // setup_q marks the first REQ cycle, where the address is captured and arvalid stays low.
  logic                setup_q, setup_d;
  // hs_done_q remembers that the IDU took the instruction, so last_finish_i may be honoured.
  logic                hs_done_q, hs_done_d;
  logic [ADDR_LEN-1:0] araddr_q, araddr_d;
  logic [ADDR_LEN-1:0] inst_pc_q, inst_pc_d;
  logic [DATA_LEN-1:0] inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic                inst_fault_q, inst_fault_d;

  logic                misaligned;
  logic                idu_hs;

  assign misaligned   = |pc_i[1:0];
  assign idu_hs       = inst_valid_q & inst_ready_i;

  assign con_state_o  = state_q;
  assign arvalid_o    = (state_q == StReq) && !setup_q;
  assign rready_o     = (state_q == StResp);
  assign araddr_o     = araddr_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_fault_o = inst_fault_q;

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    setup_d      = setup_q;
    hs_done_d    = hs_done_q;
    araddr_d     = araddr_q;
    inst_pc_d    = inst_pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    inst_fault_d = inst_fault_q;

    unique case (state_q)
      StIdle: begin
        state_d   = StReq;
        setup_d   = 1'b1;
        araddr_d  = pc_i;
        inst_pc_d = pc_i;
      end
      StReq: begin
        if (setup_q) begin
          // pc_i has settled after the counter update; capture it before requesting.
          setup_d   = 1'b0;
          araddr_d  = pc_i;
          inst_pc_d = pc_i;
          if (misaligned) begin
            state_d      = StWaitFinish;
            hs_done_d    = 1'b0;
            inst_d       = '0;
            inst_fault_d = 1'b1;
            inst_valid_d = 1'b1;
          end
        end else if (arready_i) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rvalid_i) begin
          state_d      = StWaitFinish;
          hs_done_d    = 1'b0;
          inst_d       = rdata_i;
          inst_fault_d = (rresp_i != 2'b00);
          inst_valid_d = 1'b1;
        end
      end
      StWaitFinish: begin
        if (idu_hs) begin
          inst_valid_d = 1'b0;
          hs_done_d    = 1'b1;
        end
        // A finish pulse before the IDU handshake belongs to an older instruction.
        if (last_finish_i && (hs_done_q || idu_hs)) begin
          state_d   = StReq;
          setup_d   = 1'b1;
          hs_done_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State register with synchronous active-low reset; reset abandons any bus beat in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      setup_q      <= 1'b0;
      hs_done_q    <= 1'b0;
      araddr_q     <= '0;
      inst_pc_q    <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      setup_q      <= setup_d;
      hs_done_q    <= hs_done_d;
      araddr_q     <= araddr_d;
      inst_pc_q    <= inst_pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_fault_q <= inst_fault_d;
    end
  end

endmodule
